// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers of the MIPS datapath.
// Holds the ID/EX payload widths, the bubble control word and the occupancy encoding.
package pipe_pkg;

    localparam int ID_EX_DATA_W = 35;
    localparam int ID_EX_CTRL_W = 13;

    localparam logic [ID_EX_CTRL_W-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry (valid, data, ctrl) of the stage register.
// clear drops the beat and zeroes ctrl so a cleared entry always reads as a bubble.
module pipe_entry #(
    parameter int DATA_W = 35,
    parameter int CTRL_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              valid_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= valid_d;
            data  <= data_d;
            ctrl  <= ctrl_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main + skid entry with valid/ready handshake and flush.
// in_ready depends only on registered skid state, so out_ready never reaches it combinationally.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    state_t state_q, state_d;

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    logic              main_load, skid_load;
    logic              main_valid_d, skid_valid_d;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_d, skid_ctrl_d;

    logic accept, consume;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    assign accept  = in_valid && in_ready;
    assign consume = main_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        main_load    = 1'b0;
        main_valid_d = 1'b0;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
        skid_load    = 1'b0;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = in_ctrl;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load    = 1'b1;
                    main_valid_d = 1'b1;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_load    = 1'b1;
                    main_valid_d = 1'b1;
                end else if (accept) begin
                    skid_load    = 1'b1;
                    skid_valid_d = 1'b1;
                    state_d      = FULL;
                end else if (consume) begin
                    main_load    = 1'b1;
                    main_ctrl_d  = '0;
                    state_d      = EMPTY;
                end
            end
            FULL: begin
                // Skid drains into main; in_ready is low so no new beat arrives here.
                if (consume) begin
                    main_load    = 1'b1;
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data;
                    main_ctrl_d  = skid_ctrl;
                    skid_load    = 1'b1;
                    skid_ctrl_d  = '0;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .clear   (flush),
        .valid_d (main_valid_d),
        .data_d  (main_data_d),
        .ctrl_d  (main_ctrl_d),
        .valid   (main_valid),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (flush),
        .valid_d (skid_valid_d),
        .data_d  (in_data),
        .ctrl_d  (skid_ctrl_d),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three widths driven with one handshake stream, checked
// against a two-deep FIFO reference model of the stage.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [15:0] in_ctrl = '0;

    logic        rdy35, vld35, rdy8, vld8, rdy64, vld64;
    logic [34:0] dat35;
    logic [12:0] ctl35;
    logic [7:0]  dat8;
    logic [0:0]  ctl8;
    logic [63:0] dat64;
    logic [15:0] ctl64;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] c;
    } beat_t;
    beat_t q[$];

    localparam logic [63:0] DM35 = (64'd1 << 35) - 64'd1;
    localparam logic [63:0] CM13 = (64'd1 << 13) - 64'd1;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(35), .CTRL_W(13)) u_d35 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy35), .in_data(in_data[34:0]), .in_ctrl(in_ctrl[12:0]),
        .out_valid(vld35), .out_ready(out_ready), .out_data(dat35), .out_ctrl(ctl35)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(1)) u_d8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data[7:0]), .in_ctrl(in_ctrl[0:0]),
        .out_valid(vld8), .out_ready(out_ready), .out_data(dat8), .out_ctrl(ctl8)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16)) u_d64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(vld64), .out_ready(out_ready), .out_data(dat64), .out_ctrl(ctl64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic  ev;
        logic  er;
        beat_t h;
        ev = (q.size() != 0);
        er = (q.size() < 2);
        h  = ev ? q[0] : '0;
        check({tag, ".rdy35"}, 64'(rdy35), 64'(er));
        check({tag, ".rdy8"},  64'(rdy8),  64'(er));
        check({tag, ".rdy64"}, 64'(rdy64), 64'(er));
        check({tag, ".vld35"}, 64'(vld35), 64'(ev));
        check({tag, ".vld8"},  64'(vld8),  64'(ev));
        check({tag, ".vld64"}, 64'(vld64), 64'(ev));
        check({tag, ".ctl35"}, 64'(ctl35), ev ? (64'(h.c) & CM13) : 64'd0);
        check({tag, ".ctl8"},  64'(ctl8),  ev ? (64'(h.c) & 64'd1) : 64'd0);
        check({tag, ".ctl64"}, 64'(ctl64), ev ? 64'(h.c) : 64'd0);
        if (ev) begin
            check({tag, ".dat35"}, 64'(dat35), h.d & DM35);
            check({tag, ".dat8"},  64'(dat8),  h.d & 64'hFF);
            check({tag, ".dat64"}, dat64, h.d);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rdy35"}, 64'(rdy35), 64'd1);
        check({tag, ".rdy8"},  64'(rdy8),  64'd1);
        check({tag, ".rdy64"}, 64'(rdy64), 64'd1);
        check({tag, ".vld35"}, 64'(vld35), 64'd0);
        check({tag, ".vld8"},  64'(vld8),  64'd0);
        check({tag, ".vld64"}, 64'(vld64), 64'd0);
        check({tag, ".ctl35"}, 64'(ctl35), 64'd0);
        check({tag, ".ctl8"},  64'(ctl8),  64'd0);
        check({tag, ".ctl64"}, 64'(ctl64), 64'd0);
        check({tag, ".dat35"}, 64'(dat35), 64'd0);
        check({tag, ".dat8"},  64'(dat8),  64'd0);
        check({tag, ".dat64"}, dat64, 64'd0);
    endtask

    // One clock cycle: drive inputs, check the presented state, then advance the model.
    task automatic step(input logic iv, input logic [63:0] d, input logic [15:0] c,
                        input logic ordy, input logic fl, input string tag);
        logic acc;
        logic con;
        beat_t b;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_model(tag);
        acc = iv && (q.size() < 2);
        con = ordy && (q.size() != 0);
        b.d = d;
        b.c = c;
        @(posedge clk);
        #1;
        if (con) void'(q.pop_front());
        if (acc) q.push_back(b);
        if (fl) q.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= 5; i++) step(1'b1, 64'(i), 16'h1A05, 1'b1, 1'b0, "stream");
        repeat (2) step(1'b0, 64'd0, 16'h0, 1'b1, 1'b0, "stream_drain");

        step(1'b1, 64'h10, 16'h1A05, 1'b1, 1'b0, "bp");
        step(1'b1, 64'h11, 16'h1A05, 1'b0, 1'b0, "bp");
        step(1'b1, 64'h12, 16'h1A05, 1'b0, 1'b0, "bp_stall");
        step(1'b1, 64'h12, 16'h1A05, 1'b0, 1'b0, "bp_stall");
        for (int i = 0; i < 4; i++) step(1'b1, 64'h12, 16'h1A05, 1'b1, 1'b0, "bp_release");
        repeat (2) step(1'b0, 64'd0, 16'h0, 1'b1, 1'b0, "bp_drain");

        step(1'b1, 64'h20, 16'h1A05, 1'b0, 1'b0, "fl_full");
        step(1'b1, 64'h21, 16'h1A05, 1'b0, 1'b0, "fl_full");
        step(1'b1, 64'h22, 16'h1A05, 1'b0, 1'b1, "fl_full");
        repeat (2) step(1'b0, 64'd0, 16'h0, 1'b1, 1'b0, "fl_full_after");

        step(1'b1, 64'h30, 16'h1A05, 1'b1, 1'b0, "fl_cons");
        step(1'b0, 64'd0, 16'h0, 1'b1, 1'b1, "fl_cons");
        repeat (2) step(1'b0, 64'd0, 16'h0, 1'b1, 1'b0, "fl_cons_after");

        step(1'b1, 64'hFFFF_FFFF_FFFF_FF40, 16'hFFFF, 1'b0, 1'b0, "arst_fill");
        step(1'b1, 64'hA5A5_5A5A_0000_0041, 16'h8001, 1'b0, 1'b0, "arst_fill");
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_model("arst_full");
        #1;
        reset = 1'b0;
        #1;
        q.delete();
        check_reset_state("arst");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, 16'($urandom()),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, "rand");
        end
        repeat (3) step(1'b0, 64'd0, 16'h0, 1'b1, 1'b0, "final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for the pipelined MIPS datapath. It is the next generation of the fixed ID/EX latch, with configurable data and control widths and a valid/ready handshake. A two-entry skid buffer gives full throughput under back-pressure, and a flush input inserts a bubble. One instance sits between each pair of pipeline stages; the ID/EX instance carries A, B and the instruction as data, and the 13 controller bits as control.

## Interface
- DATA_W, 35, width of datapath payload (ID/EX: 8 A + 8 B + 19 instruction)
- CTRL_W, 13, width of control payload; zero control word is the bubble (no mem/reg/flag writes)
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- flush  in  1  synchronous; discard all held entries and this cycle's input
- in_valid  in  1  upstream has a beat
- in_ready  out  1  stage can accept a beat
- in_data  in  DATA_W  upstream datapath payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  stage presents a beat
- out_ready  in  1  downstream consumes the beat
- out_data  out  DATA_W  presented datapath payload
- out_ctrl  out  CTRL_W  presented control payload, forced to 0 when out_valid=0

## Operation
- Two entries: main (drives outputs) and skid. Each entry has valid, data and ctrl.
- Accept: in_valid & in_ready. Consume: out_valid & out_ready.
- in_ready = !skid_valid. It is a registered term with no combinational path from out_ready.
- out_valid = main_valid. out_data = main_data. out_ctrl = main_valid ? main_ctrl : 0.
- States: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1).
- Transitions from EMPTY:
  - accept -> ONE, main <= in.
- Transitions from ONE:
  - accept & consume -> ONE, main <= in.
  - accept & !consume -> FULL, skid <= in.
  - !accept & consume -> EMPTY.
  - otherwise hold.
- Transitions from FULL (in_ready=0):
  - consume -> ONE, main <= skid.
  - otherwise hold.
- flush=1 (any state): next state EMPTY, both valid bits 0, both ctrl registers 0.
  - An accept in the same cycle completes the handshake, but the beat is discarded.
  - A consume in the same cycle completes normally.
  - flush has priority over every other transition.
- Data registers may retain stale values when invalid. Ctrl registers are never stale-nonzero after flush or reset.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.

## Timing
- Reset (reset=0):
  - outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - internal: all entries zero, state EMPTY.
  - asserting reset mid-transfer drops everything asynchronously.
  - after reset rises, the first accept is possible on the next clock edge.
- Latency: one cycle. A beat accepted at edge N is presented on out_* after edge N.
- Throughput: one beat per cycle when out_ready is held high.
- Back-pressure: after out_ready falls, one further beat is absorbed into skid. in_ready falls the cycle after that beat is accepted.
- Recovery: in_ready rises the cycle after FULL drains to ONE.
- flush takes effect at the next edge. The cycle after a flush shows out_valid=0, out_ctrl=0, in_ready=1.

## Structure
- Shared package pipe_pkg:
  - ID_EX_DATA_W=35, ID_EX_CTRL_W=13.
  - CTRL_BUBBLE (all zeros).
  - state encoding localparams EMPTY/ONE/FULL.
- Sub-module pipe_entry:
  - one entry (valid, data, ctrl) with async active-low reset, load enable and synchronous clear.
  - clear zeroes valid and ctrl.
  - instantiated twice (main, skid).
- Top level holds the state/handshake logic only.

## Test plan
- Reset and stream: reset low, then release. Drive in_valid=1 with out_ready=1 and data 0x01..0x05, ctrl 0x1A05.
  -> out_valid first high after edge 1; data 0x01..0x05 in order; in_ready=1 throughout.
- Back-pressure: while streaming 0x10,0x11,0x12, drop out_ready for 3 cycles.
  -> main=0x10, skid=0x11, in_ready=0 during the stall. On release, out shows 0x10,0x11,0x12 with no loss.
- Flush in FULL: in FULL with 0x20/0x21, assert flush with in_valid=1, in_data=0x22.
  -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x20/0x21/0x22 never appear.
- Flush with consume: in ONE, flush=1 and out_ready=1 in the same cycle.
  -> the beat counts as consumed once; the stage is then EMPTY.
- Async reset mid-FULL: pull reset low between edges.
  -> out_valid, out_ctrl and out_data go to 0 and in_ready to 1 immediately, without a clock edge.
- Width sweep: rerun the stream test with DATA_W=8, CTRL_W=1 and DATA_W=64, CTRL_W=16.
  -> identical handshake sequence; payload bits intact.
